// File: rtl/alu_operand_stage.sv
// -----------------------------------------------------------------------------
// alu_operand_stage
//
// Registered B-operand select for the ALU. One of NSRC packed sources is
// chosen per instruction and latched into the ID/EX-side operand register.
//   source 0     : register file
//   source 1     : immediate field (low IMMW bits, zero- or sign-extended here)
//   source 2     : EX/MEM forward
//   source 3     : MEM/WB forward
//   source 4..   : spare
//
// Ports
//   i_clk       clock, all state changes on the rising edge
//   i_reset     synchronous active-high reset (highest priority)
//   i_valid     incoming instruction is valid this cycle
//   i_stall     hold the stage contents
//   i_flush     kill the stage contents (insert a bubble), beats i_stall
//   i_sel       source index
//   i_src       packed sources, source k at [k*NBITS +: NBITS]
//   i_zero_ext  source 1 only: 1 = zero-extend, 0 = sign-extend
//   o_operand   registered selected operand
//   o_valid     registered valid
//   o_sel_err   registered illegal-select flag (only raised for valid slots)
//   o_src_idx   registered index that produced o_operand
//
// Valid semantics: there is no back-pressure handshake. o_valid qualifies
// o_operand/o_sel_err in the same cycle; a stalled stage re-presents the same
// slot unchanged, and a loaded i_valid=0 is an ordinary empty slot whose
// operand/index bits are don't-care.
// -----------------------------------------------------------------------------
module alu_operand_stage #(
   parameter int NBITS = 32,
   parameter int NSRC  = 4,
   parameter int SELW  = 3,
   parameter int IMMW  = 16
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_valid,
   input  logic                  i_stall,
   input  logic                  i_flush,
   input  logic [SELW-1:0]       i_sel,
   input  logic [NSRC*NBITS-1:0] i_src,
   input  logic                  i_zero_ext,
   output logic [NBITS-1:0]      o_operand,
   output logic                  o_valid,
   output logic                  o_sel_err,
   output logic [SELW-1:0]       o_src_idx
);

   // Elaboration-time parameter sanity checks.
   generate
      if ((1 << SELW) < NSRC) begin : g_bad_selw
         $error("alu_operand_stage: SELW too narrow for NSRC");
      end
      if (IMMW > NBITS) begin : g_bad_immw
         $error("alu_operand_stage: IMMW must not exceed NBITS");
      end
   endgenerate

   // Immediate extension. Only the low IMMW bits of source 1 are meaningful;
   // the upper bits of that slot are deliberately ignored.
   logic [IMMW-1:0]  imm_raw;
   logic [NBITS-1:0] imm_ext;

   assign imm_raw = i_src[NBITS +: IMMW];

   generate
      if (IMMW == NBITS) begin : g_imm_full
         assign imm_ext = imm_raw;
      end else begin : g_imm_ext
         logic fill;
         assign fill    = ~i_zero_ext & imm_raw[IMMW-1];
         assign imm_ext = {{(NBITS-IMMW){fill}}, imm_raw};
      end
   endgenerate

   // Source select. An index with no matching source leaves next_operand at
   // zero and raises next_err.
   logic [NBITS-1:0] next_operand;
   logic             next_err;

   always_comb begin
      next_operand = '0;
      next_err     = 1'b1;
      for (int k = 0; k < NSRC; k++) begin
         if (i_sel == SELW'(k)) begin
            next_err     = 1'b0;
            next_operand = (k == 1) ? imm_ext : i_src[k*NBITS +: NBITS];
         end
      end
   end

   // Priority: reset > flush > stall > load. Reset and flush both empty the
   // stage completely, so they share one branch.
   always_ff @(posedge i_clk) begin
      if (i_reset || i_flush) begin
         o_operand <= '0;
         o_valid   <= 1'b0;
         o_sel_err <= 1'b0;
         o_src_idx <= '0;
      end else if (!i_stall) begin
         o_operand <= next_operand;
         o_valid   <= i_valid;
         o_sel_err <= next_err & i_valid;
         o_src_idx <= i_sel;
      end
   end

endmodule

// File: tb/tb_alu_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_operand_stage
//
// Two instances: the default configuration (32/4/3/16) and a narrow one
// (16/8/3/8). Both share the control inputs and select; each has its own
// source array. A behavioural model predicts the registered state per cycle.
// -----------------------------------------------------------------------------
module tb_alu_operand_stage;

   // ---------------- clock / reset ----------------
   logic clk;
   logic reset, valid, stall, flush, zext;
   logic [2:0] sel;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- sources ----------------
   logic [31:0]  sa [4];
   logic [15:0]  sb [8];
   logic [127:0] src_a;
   logic [127:0] src_b;

   always_comb begin
      src_a = '0;
      src_b = '0;
      for (int k = 0; k < 4; k++) src_a[k*32 +: 32] = sa[k];
      for (int k = 0; k < 8; k++) src_b[k*16 +: 16] = sb[k];
   end

   // ---------------- DUTs ----------------
   logic [31:0] a_op;
   logic        a_v, a_e;
   logic [2:0]  a_idx;
   logic [15:0] b_op;
   logic        b_v, b_e;
   logic [2:0]  b_idx;

   alu_operand_stage #(.NBITS(32), .NSRC(4), .SELW(3), .IMMW(16)) dut_a (
      .i_clk(clk), .i_reset(reset), .i_valid(valid), .i_stall(stall),
      .i_flush(flush), .i_sel(sel), .i_src(src_a), .i_zero_ext(zext),
      .o_operand(a_op), .o_valid(a_v), .o_sel_err(a_e), .o_src_idx(a_idx)
   );

   alu_operand_stage #(.NBITS(16), .NSRC(8), .SELW(3), .IMMW(8)) dut_b (
      .i_clk(clk), .i_reset(reset), .i_valid(valid), .i_stall(stall),
      .i_flush(flush), .i_sel(sel), .i_src(src_b), .i_zero_ext(zext),
      .o_operand(b_op), .o_valid(b_v), .o_sel_err(b_e), .o_src_idx(b_idx)
   );

   // ---------------- scoreboard ----------------
   logic [36:0] exp_a_q [$];   // {valid, err, idx[2:0], operand[31:0]}
   logic [20:0] exp_b_q [$];   // {valid, err, idx[2:0], operand[15:0]}
   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      assert (got === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Arithmetic view of the select: take the source value; for the immediate
   // reduce it modulo 2^immw and, in signed mode, reinterpret it as negative
   // when it is at least 2^(immw-1), then wrap into nbits.
   function automatic longint ref_sel(input longint s, input int sl, input bit ze,
                                      input int nbits, input int nsrc, input int immw);
      longint v;
      if (sl >= nsrc) return 0;
      if (sl != 1) return s;
      v = s % (longint'(1) << immw);
      if (!ze && v >= (longint'(1) << (immw - 1))) v = v - (longint'(1) << immw);
      return v & ((longint'(1) << nbits) - 1);
   endfunction

   bit     ma_v, ma_e, mb_v, mb_e;
   int     ma_idx, mb_idx;
   longint ma_op, mb_op;

   task automatic model_update();
      int s;
      s = int'(sel);
      if (reset || flush) begin
         ma_v = 0; ma_e = 0; ma_idx = 0; ma_op = 0;
         mb_v = 0; mb_e = 0; mb_idx = 0; mb_op = 0;
      end else if (!stall) begin
         ma_op  = ref_sel((s < 4) ? longint'(sa[s]) : 0, s, zext, 32, 4, 16);
         ma_idx = s;
         ma_v   = valid;
         ma_e   = valid && (s >= 4);
         mb_op  = ref_sel(longint'(sb[s]), s, zext, 16, 8, 8);
         mb_idx = s;
         mb_v   = valid;
         mb_e   = valid && (s >= 8);
      end
      exp_a_q.push_back({ma_v, ma_e, 3'(ma_idx), 32'(ma_op)});
      exp_b_q.push_back({mb_v, mb_e, 3'(mb_idx), 16'(mb_op)});
   endtask

   // ---------------- driver ----------------
   // Inputs are already set; predict, clock once, sample 1 time unit later.
   task automatic step();
      model_update();
      @(posedge clk);
      #1;
      chk("a_state", 64'({a_v, a_e, a_idx, a_op}), 64'(exp_a_q.pop_front()));
      chk("b_state", 64'({b_v, b_e, b_idx, b_op}), 64'(exp_b_q.pop_front()));
   endtask

   task automatic randomize_sources();
      for (int k = 0; k < 4; k++) sa[k] = $urandom;
      for (int k = 0; k < 8; k++) sb[k] = 16'($urandom);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      reset = 1; valid = 0; stall = 0; flush = 0; zext = 0; sel = 0;
      for (int k = 0; k < 4; k++) sa[k] = '0;
      for (int k = 0; k < 8; k++) sb[k] = '0;

      // reset state
      step();
      chk("reset_op",    64'(a_op),  64'h0);
      chk("reset_valid", 64'(a_v),   64'h0);
      chk("reset_err",   64'(a_e),   64'h0);
      chk("reset_idx",   64'(a_idx), 64'h0);

      // register-file source
      reset = 0; valid = 1; sel = 0; sa[0] = 32'h0000_0001;
      step();
      chk("rf_op",    64'(a_op),  64'h1);
      chk("rf_valid", 64'(a_v),   64'h1);
      chk("rf_idx",   64'(a_idx), 64'h0);
      chk("rf_err",   64'(a_e),   64'h0);

      // immediate extension
      sel = 1; sa[1] = 32'hFFFF_8000; zext = 0;
      step();
      chk("imm_sext", 64'(a_op), 64'hFFFF_8000);
      zext = 1;
      step();
      chk("imm_zext", 64'(a_op), 64'h0000_8000);
      sa[1] = 32'hABCD_1234; zext = 0;
      step();
      chk("imm_upper_ignored", 64'(a_op), 64'h0000_1234);

      // stall hold then release
      sel = 2; sa[2] = 32'hDEAD_BEEF; zext = 0;
      step();
      stall = 1; sel = 3; sa[3] = 32'h5;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_op",    64'(a_op), 64'hDEAD_BEEF);
         chk("stall_valid", 64'(a_v),  64'h1);
      end
      stall = 0;
      step();
      chk("release_op",  64'(a_op),  64'h5);
      chk("release_idx", 64'(a_idx), 64'h3);

      // illegal select on the 4-source instance
      sel = 5; valid = 1;
      step();
      chk("bad_sel_op",  64'(a_op), 64'h0);
      chk("bad_sel_err", 64'(a_e),  64'h1);
      valid = 0;
      step();
      chk("bad_sel_invalid_err", 64'(a_e), 64'h0);

      // flush beats stall
      valid = 1; sel = 0; sa[0] = 32'h1234_5678;
      step();
      stall = 1; flush = 1;
      step();
      chk("flush_valid", 64'(a_v),  64'h0);
      chk("flush_op",    64'(a_op), 64'h0);
      stall = 0; flush = 0;

      // reset beats a valid load
      sel = 2; sa[2] = 32'hCAFE_F00D;
      step();
      reset = 1; valid = 1; sel = 2;
      step();
      chk("reset_load_all", 64'({a_v, a_e, a_idx, a_op}), 64'h0);
      reset = 0;

      // random traffic against the model
      for (int i = 0; i < 1000; i++) begin
         randomize_sources();
         sel   = 3'($urandom_range(0, 7));
         valid = ($urandom_range(0, 3) != 0);
         zext  = 1'($urandom);
         stall = ($urandom_range(0, 5) == 0);
         flush = ($urandom_range(0, 11) == 0);
         reset = ($urandom_range(0, 63) == 0);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Parametrised, registered successor to the two-input ALU B-operand select of the datapath.
- Selects one of NSRC packed operand sources per instruction and latches the result into the ID/EX-side operand register.
- Sources, by index: 0 = register file, 1 = immediate field (extended in this block), 2 = EX/MEM forward, 3 = MEM/WB forward, 4..NSRC-1 = spare.
- Handles pipeline stall, flush and valid tracking, and flags illegal selects.

Parameters:
- NBITS, 32, operand width in bits.
- NSRC, 4, number of operand sources (2..8).
- SELW, 3, select width; must satisfy 2^SELW >= NSRC.
- IMMW, 16, width of the raw immediate field carried in source 1 (IMMW <= NBITS).

Ports:
- i_clk  in  1  clock, all state updates on its rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  1  incoming instruction is valid this cycle.
- i_stall  in  1  hold the stage contents.
- i_flush  in  1  kill the stage contents (insert bubble).
- i_sel  in  SELW  source index.
- i_src  in  NSRC*NBITS  packed sources; source k occupies bits [k*NBITS +: NBITS].
- i_zero_ext  in  1  for source 1: 1 = zero-extend the low IMMW bits, 0 = sign-extend them.
- o_operand  out  NBITS  registered selected operand.
- o_valid  out  1  registered valid.
- o_sel_err  out  1  registered illegal-select flag.
- o_src_idx  out  SELW  registered index that produced o_operand (debug/forwarding stats).

Behaviour:
- Reset (i_reset=1 at a rising edge) forces o_operand=0, o_valid=0, o_sel_err=0, o_src_idx=0. Reset has priority over every other input. Reset mid-stall or mid-flush clears the stage identically.
- Latency: exactly 1 cycle from input to output; no combinational path from inputs to outputs.

Selection (combinational, before the register):
- i_sel < NSRC and i_sel != 1: next = i_src[i_sel*NBITS +: NBITS] unchanged.
- i_sel == 1: take the low IMMW bits of source 1; bits above IMMW are ignored. Extend to NBITS with zeros when i_zero_ext=1, else replicate bit IMMW-1. When IMMW == NBITS, pass through unchanged.
- i_sel >= NSRC: next operand = 0, next sel_err = 1. Otherwise next sel_err = 0.

Register update priority per rising edge (reset > flush > stall > load):
- Flush (i_flush=1): o_valid=0, o_operand=0, o_sel_err=0, o_src_idx=0. Flush overrides a simultaneous stall.
- Stall (i_stall=1, i_flush=0): all outputs hold their previous values, including o_valid and o_sel_err.
- Load (neither asserted): o_operand=next, o_src_idx=i_sel, o_valid=i_valid, o_sel_err=next sel_err & i_valid.
- If i_valid=0 on load, the operand and index are still captured (don't-care data), but o_valid=0 and o_sel_err=0.

Other rules:
- Bubbles propagate: a loaded i_valid=0 behaves as a normal empty slot; no special state.
- No internal state beyond the four output registers. Implement the priority as a small 3-state view (EMPTY/HOLD/LOADED) or as a direct priority mux.
- Widths: no truncation except the intended IMMW slice; parameter checks via generate-time error when 2^SELW < NSRC or IMMW > NBITS.

Test Plan:
- Reset then load, i_valid=1, i_sel=0, src0=32'h0000_0001 -> next cycle o_operand=1, o_valid=1, o_src_idx=0, o_sel_err=0.
- i_sel=1, src1=32'hFFFF_8000, i_zero_ext=0 -> o_operand=32'hFFFF_8000. Same with i_zero_ext=1 -> 32'h0000_8000. src1=32'hABCD_1234, sign mode -> 32'h0000_1234.
- Load src2=32'hDEAD_BEEF (sel=2), then 3 cycles of i_stall=1 while i_sel=3 and src3=5 -> o_operand stays 32'hDEAD_BEEF, o_valid=1. On stall release -> 5 with o_src_idx=3.
- i_sel=5 with NSRC=4, i_valid=1 -> o_operand=0, o_sel_err=1. Same select with i_valid=0 -> o_sel_err=0.
- i_stall=1 and i_flush=1 together while the stage holds valid data -> next cycle o_valid=0, o_operand=0. i_reset=1 with i_valid=1, i_sel=2 -> all outputs 0.
- Sweep i_sel 0..NSRC-1 with random sources over 1000 cycles against a 1-cycle-delayed reference model. Rerun with NBITS=16, NSRC=8, SELW=3, IMMW=8.
